// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA requester and the single-port D-memory.
// The slave view belongs to the arbiter; the master view is the surrounding system.
interface dmem_arbiter_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [ASIZE-1:0] cpu_addr;
  logic [DSIZE-1:0] cpu_wdata;
  logic [DSIZE-1:0] cpu_rdata;
  logic             cpu_stall;

  logic             dma_req;
  logic             dma_we;
  logic [ASIZE-1:0] dma_addr;
  logic [3:0]       dma_len;
  logic [DSIZE-1:0] dma_wdata;
  logic             dma_gnt;
  logic             dma_wready;
  logic             dma_rvalid;
  logic [DSIZE-1:0] dma_rdata;
  logic             dma_done;

  logic [ASIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata;
  logic             mem_we;
  logic [DSIZE-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_gnt, dma_wready, dma_rvalid, dma_rdata, dma_done,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_gnt, dma_wready, dma_rvalid, dma_rdata, dma_done,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-port D-memory between the CPU MEM stage and a burst DMA engine.
//   state | meaning
//   IDLE  | CPU served; DMA granted when CPU idle or DMA starved
//   BURST | one DMA beat per cycle at base+beat, CPU stalled
//   YIELD | one guaranteed CPU cycle after a burst, dma_done pulses
module dmem_arbiter #(
  parameter int DSIZE      = 16,
  parameter int ASIZE      = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, BURST, YIELD} state_t;

  state_t           state;
  logic [ASIZE-1:0] base;
  logic [3:0]       len;
  logic [3:0]       beat;
  logic             we_lat;
  logic [CW-1:0]    starve_cnt;
  logic             done_q;

  logic grant;
  logic cpu_sel;
  logic burst_act;

  // Everything combinational is masked by reset so a mid-burst reset kills the write at once.
  always_comb begin
    grant   = 1'b0;
    cpu_sel = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dma_req && (!bus.cpu_req || starve_cnt == LIM)) grant = 1'b1;
        else                                                    cpu_sel = bus.cpu_req;
      end
      YIELD:   cpu_sel = bus.cpu_req;
      default: ;
    endcase
    if (!rst) begin
      grant   = 1'b0;
      cpu_sel = 1'b0;
    end
  end

  assign burst_act = rst && (state == BURST);

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_sel) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (burst_act) begin
      bus.mem_we   = we_lat;
      bus.mem_addr = base + ASIZE'(beat);
      if (we_lat) bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_stall  = rst && bus.cpu_req && !cpu_sel;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.dma_gnt    = grant;
  assign bus.dma_wready = burst_act && we_lat;
  assign bus.dma_rvalid = burst_act && !we_lat;
  assign bus.dma_done   = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      beat       <= '0;
      we_lat     <= 1'b0;
      starve_cnt <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            base       <= bus.dma_addr;
            len        <= bus.dma_len;
            we_lat     <= bus.dma_we;
            beat       <= '0;
            starve_cnt <= '0;
            state      <= BURST;
          end else if (bus.cpu_req && bus.dma_req && starve_cnt != LIM) begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        BURST: begin
          beat <= beat + 4'd1;
          if (beat == len) begin
            beat   <= '0;
            done_q <= 1'b1;
            state  <= YIELD;
          end
        end
        YIELD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: behavioral D-memory, expected DMA beats queued at request time
// and compared by a monitor whenever the arbiter issues a beat.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DSIZE(16), .ASIZE(16)) bus();

  dmem_arbiter #(.DSIZE(16), .ASIZE(16), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        we;
  } beat_t;
  beat_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] wpat(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic [15:0] ipat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(negedge clk) begin
    if (rst && (bus.dma_rvalid || bus.dma_wready)) begin
      if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_addr", bus.mem_addr, e.addr);
        chk("beat_dir",  bus.mem_we,   e.we);
        chk("beat_data", e.we ? bus.mem_wdata : bus.dma_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic we, input logic [15:0] addr, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.addr = addr + 16'(i);
      e.we   = we;
      e.data = we ? wpat(e.addr) : mem[e.addr];
      exp_q.push_back(e);
    end
  endtask

  // Full burst with the CPU idle; request fields are scrambled after grant.
  task automatic dma_burst(input logic we, input logic [15:0] addr, input logic [3:0] len);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_len = len;
    push_beats(we, addr, int'(len) + 1);
    @(negedge clk);
    chk("gnt", bus.dma_gnt, 1);
    chk("gnt_no_mem", bus.mem_we, 0);
    tick();
    bus.dma_addr = ~addr; bus.dma_len = ~len; bus.dma_we = ~we;
    for (int i = 0; i <= int'(len); i++) begin
      bus.dma_wdata = wpat(addr + 16'(i));
      @(negedge clk);
      chk("gnt_pulse", bus.dma_gnt, 0);
      chk("no_early_done", bus.dma_done, 0);
      tick();
    end
    @(negedge clk);
    chk("done", bus.dma_done, 1);
    tick();
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_len = '0; bus.dma_wdata = '0;
    @(negedge clk);
    chk("done_pulse", bus.dma_done, 0);
  endtask

  initial begin
    int done_cnt;
    for (int i = 0; i < 65536; i++) mem[i] = ipat(16'(i));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h1234;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = '0; bus.dma_len = '0; bus.dma_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_stall",  bus.cpu_stall, 0);
    chk("rst_gnt",    bus.dma_gnt, 0);
    chk("rst_done",   bus.dma_done, 0);
    chk("rst_wready", bus.dma_wready, 0);
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    rst = 1'b1;
    tick();

    // CPU store then load
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
    @(negedge clk);
    chk("st_we", bus.mem_we, 1);
    chk("st_addr", bus.mem_addr, 16'h0010);
    chk("st_data", bus.mem_wdata, 16'hBEEF);
    chk("st_stall", bus.cpu_stall, 0);
    tick();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("ld_data", bus.cpu_rdata, 16'hBEEF);
    chk("ld_stall", bus.cpu_stall, 0);
    chk("ld_we", bus.mem_we, 0);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("idle_addr", bus.mem_addr, 0);
    chk("idle_we", bus.mem_we, 0);
    tick();

    dma_burst(1'b0, 16'h0100, 4'd3);
    tick();
    dma_burst(1'b1, 16'hFFFE, 4'd2);
    tick();

    // Wrapped write landed at 0x0000
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0000;
    @(negedge clk);
    chk("wrap_rd0", bus.cpu_rdata, wpat(16'h0000));
    tick();
    bus.cpu_addr = 16'hFFFF;
    @(negedge clk);
    chk("wrap_rdF", bus.cpu_rdata, wpat(16'hFFFF));
    tick();

    // Starvation: CPU and DMA both held high
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0200; bus.dma_len = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      bus.cpu_addr = 16'h0300 + 16'(i);
      @(negedge clk);
      chk("stv_cpu_stall", bus.cpu_stall, 0);
      chk("stv_cpu_gnt", bus.dma_gnt, 0);
      chk("stv_cpu_addr", bus.mem_addr, 16'h0300 + 16'(i));
      tick();
    end
    bus.cpu_we = 1'b1; bus.cpu_wdata = 16'hDEAD; bus.cpu_addr = 16'h0310;
    push_beats(1'b0, 16'h0200, 2);
    @(negedge clk);
    chk("stv_gnt", bus.dma_gnt, 1);
    chk("stv_stall", bus.cpu_stall, 1);
    chk("stv_mem_we", bus.mem_we, 0);
    tick();
    bus.cpu_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("burst_stall", bus.cpu_stall, 1);
      tick();
    end
    @(negedge clk);
    chk("yld_done", bus.dma_done, 1);
    chk("yld_stall", bus.cpu_stall, 0);
    chk("yld_gnt", bus.dma_gnt, 0);
    chk("yld_addr", bus.mem_addr, 16'h0310);
    tick();
    @(negedge clk);
    chk("post_cnt_clr_gnt", bus.dma_gnt, 0);
    chk("post_cnt_clr_stall", bus.cpu_stall, 0);
    tick();
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    chk("cpu_store_blocked", mem[16'h0310], ipat(16'h0310));
    tick();

    // Reset during beat 1 of a len=7 write burst
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0400; bus.dma_len = 4'd7;
    push_beats(1'b1, 16'h0400, 1);
    @(negedge clk);
    chk("rb_gnt", bus.dma_gnt, 1);
    tick();
    bus.dma_wdata = wpat(16'h0400);
    tick();
    bus.dma_wdata = wpat(16'h0401);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_mem_we", bus.mem_we, 0);
    chk("rb_wready", bus.dma_wready, 0);
    tick();
    bus.dma_req = 1'b0;
    tick();
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dma_done) done_cnt++;
    end
    chk("rb_no_done", done_cnt, 0);
    chk("rb_beat0", mem[16'h0400], wpat(16'h0400));
    chk("rb_beat1", mem[16'h0401], ipat(16'h0401));
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0400;
    @(negedge clk);
    chk("rb_idle_stall", bus.cpu_stall, 0);
    chk("rb_idle_rd", bus.cpu_rdata, wpat(16'h0400));
    tick();
    bus.cpu_req = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DSIZE, 16, data width of memory and both requesters.
REQ-002 Parameter: ASIZE, 16, address width.
REQ-003 Parameter: STARVE_LIM, 4, consecutive denied DMA cycles before DMA overrides CPU.
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: cpu_req  in  1  MEM-stage access valid this cycle.
REQ-007 Port: cpu_we  in  1  MEM-stage access is a store.
REQ-008 Port: cpu_addr  in  ASIZE  MEM-stage address.
REQ-009 Port: cpu_wdata  in  DSIZE  store data.
REQ-010 Port: cpu_rdata  out  DSIZE  load data; equals mem_rdata.
REQ-011 Port: cpu_stall  out  1  freezes the pipeline; CPU access not performed this cycle.
REQ-012 Port: dma_req  in  1  level request for a burst.
REQ-013 Port: dma_we  in  1  burst direction, 1 = write to memory.
REQ-014 Port: dma_addr  in  ASIZE  burst base address.
REQ-015 Port: dma_len  in  4  burst length minus one (1..16 words).
REQ-016 Port: dma_wdata  in  DSIZE  current write word.
REQ-017 Port: dma_gnt  out  1  one-cycle pulse when the burst is accepted.
REQ-018 Port: dma_wready  out  1  current dma_wdata consumed this cycle.
REQ-019 Port: dma_rvalid  out  1  dma_rdata valid this cycle.
REQ-020 Port: dma_rdata  out  DSIZE  read word; equals mem_rdata.
REQ-021 Port: dma_done  out  1  one-cycle pulse in the cycle after the last beat.
REQ-022 Port: mem_addr / mem_wdata / mem_we  out  ASIZE/DSIZE/1  to single-port D-memory; write occurs on the clk edge; combinational read returns mem_rdata in the same cycle.
REQ-023 Port: mem_rdata  in  DSIZE  memory read data.

Function
REQ-024 The FSM SHALL have the states IDLE, BURST and YIELD.
REQ-025 IDLE with cpu_req: mem_* driven from cpu_*, cpu_stall=0, unless the starvation override (REQ-027) applies.
REQ-026 IDLE with dma_req and no cpu_req: latch dma_addr, dma_len and dma_we; pulse dma_gnt; set beat=0; go to BURST next cycle; no memory access this cycle.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_LIM, on each IDLE cycle with dma_req&&cpu_req; when it equals STARVE_LIM, DMA wins: cpu_stall=1, mem_we=0, grant as in REQ-026.
REQ-028 starve_cnt SHALL clear on every dma_gnt.
REQ-029 BURST: mem_addr = base+beat, modulo 2^ASIZE (0xFFFF+1 wraps to 0x0000).
REQ-030 BURST: cpu_stall=cpu_req.
REQ-031 BURST write: mem_we=1, mem_wdata=dma_wdata, dma_wready=1.
REQ-032 BURST read: mem_we=0, dma_rvalid=1.
REQ-033 BURST: beat increments each cycle; after the beat==len cycle go to YIELD; dma_done pulses in the YIELD cycle.
REQ-034 YIELD lasts one cycle: the CPU is served as in IDLE with no override, dma_req is ignored, then the FSM goes to IDLE.
REQ-035 Changes to dma_addr, dma_len or dma_we after grant SHALL be ignored until the next grant.
REQ-036 The DMA requester deasserts dma_req on dma_done; dma_req still high in IDLE starts a new burst.
REQ-037 With no access selected: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-038 Latency: a CPU access completes in its request cycle when not stalled; a DMA burst occupies len+1 memory cycles starting 1 cycle after dma_gnt.

Reset
REQ-039 While rst=0: state=IDLE, beat=0, starve_cnt=0, latched burst registers=0; dma_gnt, dma_done, dma_wready, dma_rvalid, mem_we and cpu_stall SHALL all be 0.
REQ-040 rst asserted mid-burst SHALL abort immediately: no further memory writes, and no dma_done is issued.

Verification
REQ-041 cpu_req=1, cpu_we=1, addr 0x0010, data 0xBEEF, no DMA -> mem_we=1 the same cycle; a later load of 0x0010 returns 0xBEEF with cpu_stall=0.
REQ-042 dma_req=1, we=0, addr 0x0100, len=3, CPU idle -> dma_gnt at T; dma_rvalid T+1..T+4 with addresses 0x0100..0x0103; dma_done at T+5.
REQ-043 cpu_req and dma_req held high continuously -> 4 CPU cycles served, DMA granted in the 5th cycle with cpu_stall=1, starve_cnt back to 0.
REQ-044 Write burst addr 0xFFFE, len=2 -> writes to 0xFFFE, 0xFFFF, 0x0000; dma_wready high for 3 cycles.
REQ-045 rst pulled low during beat 1 of a len=7 write burst -> mem_we=0 immediately; after release state=IDLE and no dma_done pulse.
REQ-046 dma_req still high at dma_done with cpu_req=1 -> YIELD serves the CPU, then a new grant only per REQ-026/REQ-027.
